// File: rtl/Structures.sv
// Shared stream types for the receive and measurement chain.
//
// COMPLEX_STREAM: one complex sample per cycle.
//   I, Q  : 18-bit two's-complement components
//   Valid : high for exactly the cycles that carry a new sample
package Structures;

  typedef struct packed {
    logic signed [17:0] I;
    logic signed [17:0] Q;
    logic               Valid;
  } COMPLEX_STREAM;

endpackage

// File: rtl/complex_stream_source.sv
// complex_stream_source
//
// On-chip quadrature test-signal transmitter. It emits a four-phase rotating
// phasor (A,0), (0,A), (-A,0), (0,-A) on a COMPLEX_STREAM, one sample every
// (divider + 1) clocks. It runs either for a fixed-length burst or
// continuously (burst length 0).
//
// Ports
//   ipClk          in   system clock, rising edge
//   ipReset        in   asynchronous, active-high reset
//   ipStart        in   one-cycle pulse, starts a burst when idle
//   ipAbort        in   one-cycle pulse, terminates the current burst
//   ipRateDivider  in   [15:0] sample interval in clocks minus 1, latched at start
//   ipBurstLength  in   [7:0]  samples per burst, 0 = continuous, latched at start
//   ipAmplitude    in   [7:0]  amplitude code, sampled on every phase-0 sample
//   opOutput       out  generated stream (registered)
//   opBusy         out  high while a burst is active (registered)
module complex_stream_source (
  input  logic                      ipClk,
  input  logic                      ipReset,
  input  logic                      ipStart,
  input  logic                      ipAbort,
  input  logic [15:0]               ipRateDivider,
  input  logic [7:0]                ipBurstLength,
  input  logic [7:0]                ipAmplitude,
  output Structures::COMPLEX_STREAM opOutput,
  output logic                      opBusy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_WAIT
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               div_q, div_d;
  logic [7:0]                len_q, len_d;
  logic [1:0]                phase_q, phase_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [15:0]               wait_q, wait_d;
  logic [7:0]                amp_q, amp_d;
  logic                      busy_q, busy_d;
  Structures::COMPLEX_STREAM out_q, out_d;

  logic [7:0]                amp_sel;
  logic [17:0]               mag;
  logic [17:0]               neg;

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    div_d       = div_q;
    len_d       = len_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    amp_d       = amp_q;
    out_d       = out_q;      // I/Q hold their last value between samples
    out_d.Valid = 1'b0;
    amp_sel     = amp_q;
    mag         = '0;
    neg         = '0;

    // Busy trails the state by one cycle; an abort drops it at the same edge
    // that forces the FSM back to idle.
    busy_d = (state_q != ST_IDLE) && !ipAbort;

    unique case (state_q)
      ST_IDLE: begin
        // Abort wins over a simultaneous start; the busy gate keeps a start
        // during the trailing busy cycle of the previous burst from counting.
        if (ipStart && !ipAbort && !busy_q) begin
          state_d = ST_EMIT;
          div_d   = ipRateDivider;
          len_d   = ipBurstLength;
          phase_d = 2'd0;
          cnt_d   = 8'd0;
        end
      end

      ST_EMIT: begin
        // Amplitude is taken live on phase 0 and reused for phases 1-3, so a
        // whole rotation always has one magnitude.
        amp_sel = (phase_q == 2'd0) ? ipAmplitude : amp_q;
        amp_d   = amp_sel;
        mag     = {1'b0, amp_sel, 9'b0};
        neg     = 18'd0 - mag;    // |mag| <= 0x1FE00, so negation cannot overflow

        out_d.Valid = 1'b1;
        case (phase_q)
          2'd0:    begin out_d.I = mag;   out_d.Q = '0;    end
          2'd1:    begin out_d.I = '0;    out_d.Q = mag;   end
          2'd2:    begin out_d.I = neg;   out_d.Q = '0;    end
          default: begin out_d.I = '0;    out_d.Q = neg;   end
        endcase

        phase_d = phase_q + 2'd1;
        cnt_d   = cnt_q + 8'd1;   // wraps freely in continuous mode

        if (ipAbort) begin
          state_d = ST_IDLE;
        end else if ((len_q != 8'd0) && (cnt_d == len_q)) begin
          state_d = ST_IDLE;
        end else if (div_q == 16'd0) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_WAIT;
          wait_d  = div_q - 16'd1;
        end
      end

      ST_WAIT: begin
        if (ipAbort) begin
          state_d = ST_IDLE;
        end else if (wait_q == 16'd0) begin
          state_d = ST_EMIT;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      len_q   <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      amp_q   <= '0;
      busy_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      len_q   <= len_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      amp_q   <= amp_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
    end
  end

  assign opOutput = out_q;
  assign opBusy   = busy_q;

endmodule

// File: tb/tb_complex_stream_source.sv
// Directed testbench for complex_stream_source. Inputs change 1 ns after a
// rising edge and outputs are observed at that same point, away from the edge.
module tb_complex_stream_source;

  logic                      ipClk = 1'b0;
  logic                      ipReset;
  logic                      ipStart;
  logic                      ipAbort;
  logic [15:0]               ipRateDivider;
  logic [7:0]                ipBurstLength;
  logic [7:0]                ipAmplitude;
  Structures::COMPLEX_STREAM opOutput;
  logic                      opBusy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Samples seen by capture(): tick index, I and Q of each Valid cycle.
  int          cap_t[$];
  logic [17:0] cap_i[$];
  logic [17:0] cap_q[$];
  int          cap_busy;

  always #5 ipClk = ~ipClk;

  complex_stream_source dut (
    .ipClk         (ipClk),
    .ipReset       (ipReset),
    .ipStart       (ipStart),
    .ipAbort       (ipAbort),
    .ipRateDivider (ipRateDivider),
    .ipBurstLength (ipBurstLength),
    .ipAmplitude   (ipAmplitude),
    .opOutput      (opOutput),
    .opBusy        (opBusy)
  );

  task automatic tick();
    @(posedge ipClk);
    #1;
  endtask

  // Presents a start pulse; returns 1 ns after the edge that samples it.
  task automatic start_burst(input logic [15:0] d, input logic [7:0] l, input logic [7:0] a);
    ipRateDivider = d;
    ipBurstLength = l;
    ipAmplitude   = a;
    ipStart       = 1'b1;
    tick();
    ipStart       = 1'b0;
  endtask

  task automatic capture(input int n);
    cap_t.delete();
    cap_i.delete();
    cap_q.delete();
    cap_busy = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (opOutput.Valid === 1'b1) begin
        cap_t.push_back(k);
        cap_i.push_back(opOutput.I);
        cap_q.push_back(opOutput.Q);
      end
      if (opBusy === 1'b1) cap_busy++;
    end
  endtask

  task automatic test_reset();
    ipReset = 1'b1;
    ipStart = 1'b0;
    ipAbort = 1'b0;
    ipRateDivider = '0;
    ipBurstLength = '0;
    ipAmplitude   = '0;
    #12;
    total_cnt++; if (opOutput.I !== 18'h0) $display("FAIL reset_i: got %h exp 0", opOutput.I); else pass_cnt++;
    total_cnt++; if (opOutput.Q !== 18'h0) $display("FAIL reset_q: got %h exp 0", opOutput.Q); else pass_cnt++;
    total_cnt++; if (opOutput.Valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", opOutput.Valid); else pass_cnt++;
    total_cnt++; if (opBusy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", opBusy); else pass_cnt++;
    ipReset = 1'b0;
    capture(3);
    total_cnt++; if (cap_t.size() != 0 || cap_busy != 0)
      $display("FAIL reset_idle: got valids=%0d busy=%0d exp 0/0", cap_t.size(), cap_busy); else pass_cnt++;
  endtask

  task automatic test_basic_burst();
    int          et[4] = '{1, 2, 3, 4};
    logic [17:0] ei[4] = '{18'h10000, 18'h00000, 18'h30000, 18'h00000};
    logic [17:0] eq[4] = '{18'h00000, 18'h10000, 18'h00000, 18'h30000};
    int gt; logic [17:0] gi, gq;
    start_burst(16'd0, 8'd4, 8'h80);
    total_cnt++; if (opBusy !== 1'b0) $display("FAIL basic_busy_latency: got %b exp 0", opBusy); else pass_cnt++;
    capture(8);
    total_cnt++; if (cap_t.size() != 4) $display("FAIL basic_count: got %0d exp 4", cap_t.size()); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      gt = (k < cap_t.size()) ? cap_t[k] : -1;
      gi = (k < cap_i.size()) ? cap_i[k] : 'x;
      gq = (k < cap_q.size()) ? cap_q[k] : 'x;
      total_cnt++;
      if (gt != et[k] || gi !== ei[k] || gq !== eq[k])
        $display("FAIL basic_s%0d: got t=%0d i=%h q=%h exp t=%0d i=%h q=%h", k, gt, gi, gq, et[k], ei[k], eq[k]);
      else pass_cnt++;
    end
    total_cnt++; if (cap_busy != 4) $display("FAIL basic_busy_len: got %0d exp 4", cap_busy); else pass_cnt++;
    total_cnt++; if (opOutput.I !== 18'h0 || opOutput.Q !== 18'h30000 || opOutput.Valid !== 1'b0)
      $display("FAIL basic_hold: got i=%h q=%h v=%b exp i=0 q=30000 v=0", opOutput.I, opOutput.Q, opOutput.Valid);
    else pass_cnt++;
  endtask

  task automatic test_divided_rate();
    int          et[5] = '{1, 4, 7, 10, 13};
    logic [17:0] ei[5] = '{18'h1FE00, 18'h00000, 18'h20200, 18'h00000, 18'h1FE00};
    logic [17:0] eq[5] = '{18'h00000, 18'h1FE00, 18'h00000, 18'h20200, 18'h00000};
    int gt; logic [17:0] gi, gq;
    start_burst(16'd2, 8'd5, 8'hFF);
    capture(18);
    total_cnt++; if (cap_t.size() != 5) $display("FAIL div_count: got %0d exp 5", cap_t.size()); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      gt = (k < cap_t.size()) ? cap_t[k] : -1;
      gi = (k < cap_i.size()) ? cap_i[k] : 'x;
      gq = (k < cap_q.size()) ? cap_q[k] : 'x;
      total_cnt++;
      if (gt != et[k] || gi !== ei[k] || gq !== eq[k])
        $display("FAIL div_s%0d: got t=%0d i=%h q=%h exp t=%0d i=%h q=%h", k, gt, gi, gq, et[k], ei[k], eq[k]);
      else pass_cnt++;
    end
    total_cnt++; if (cap_busy != 13) $display("FAIL div_busy_len: got %0d exp 13", cap_busy); else pass_cnt++;
  endtask

  // A start during the trailing busy cycle is ignored; held one cycle longer
  // it is accepted in the first busy-low cycle and restarts at phase 0.
  task automatic test_back_to_back();
    ipRateDivider = 16'd0;
    ipBurstLength = 8'd2;
    ipAmplitude   = 8'h01;
    ipStart = 1'b1;
    tick();
    ipStart = 1'b0;
    tick();  // 1
    total_cnt++; if (opOutput.Valid !== 1'b1 || opOutput.I !== 18'h200)
      $display("FAIL b2b_first: got v=%b i=%h exp v=1 i=200", opOutput.Valid, opOutput.I); else pass_cnt++;
    tick();  // 2
    total_cnt++; if (opOutput.Valid !== 1'b1 || opOutput.Q !== 18'h200 || opBusy !== 1'b1)
      $display("FAIL b2b_second: got v=%b q=%h busy=%b exp 1/200/1", opOutput.Valid, opOutput.Q, opBusy); else pass_cnt++;
    ipStart = 1'b1;
    tick();  // 3
    total_cnt++; if (opBusy !== 1'b0 || opOutput.Valid !== 1'b0)
      $display("FAIL b2b_gap: got busy=%b v=%b exp 0/0", opBusy, opOutput.Valid); else pass_cnt++;
    tick();  // 4
    ipStart = 1'b0;
    total_cnt++; if (opOutput.Valid !== 1'b0)
      $display("FAIL b2b_start_while_busy_ignored: got v=%b exp 0", opOutput.Valid); else pass_cnt++;
    tick();  // 5
    total_cnt++; if (opOutput.Valid !== 1'b1 || opOutput.I !== 18'h200 || opOutput.Q !== 18'h0)
      $display("FAIL b2b_restart: got v=%b i=%h q=%h exp 1/200/0", opOutput.Valid, opOutput.I, opOutput.Q); else pass_cnt++;
    capture(4);
    total_cnt++; if (cap_t.size() != 1) $display("FAIL b2b_tail: got %0d exp 1", cap_t.size()); else pass_cnt++;
  endtask

  task automatic test_continuous();
    logic [17:0] ei[7] = '{18'h02000, 18'h00000, 18'h3E000, 18'h00000, 18'h04000, 18'h00000, 18'h3C000};
    logic [17:0] eq[7] = '{18'h00000, 18'h02000, 18'h00000, 18'h3E000, 18'h00000, 18'h04000, 18'h00000};
    int valids = 0;
    int busys  = 0;
    int bad    = 0;
    start_burst(16'd0, 8'd0, 8'h10);
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 2) ipAmplitude = 8'h20;
      if (opOutput.Valid === 1'b1) valids++;
      if (opBusy === 1'b1) busys++;
      if (k <= 7) begin
        if (opOutput.Valid !== 1'b1 || opOutput.I !== ei[k-1] || opOutput.Q !== eq[k-1]) begin
          $display("FAIL cont_s%0d: got v=%b i=%h q=%h exp v=1 i=%h q=%h", k, opOutput.Valid, opOutput.I, opOutput.Q, ei[k-1], eq[k-1]);
          bad++;
        end
      end
    end
    total_cnt++; if (bad != 0) $display("FAIL cont_first_rotations: got %0d bad exp 0", bad); else pass_cnt++;
    total_cnt++; if (valids != 300 || busys != 300)
      $display("FAIL cont_300: got valids=%0d busy=%0d exp 300/300", valids, busys); else pass_cnt++;
    ipAbort = 1'b1;
    tick();  // 301: abort sampled during an EMIT cycle
    ipAbort = 1'b0;
    total_cnt++; if (opOutput.Valid !== 1'b1 || opOutput.I !== 18'h04000 || opBusy !== 1'b0)
      $display("FAIL cont_abort_emit: got v=%b i=%h busy=%b exp 1/04000/0", opOutput.Valid, opOutput.I, opBusy); else pass_cnt++;
    capture(10);
    total_cnt++; if (cap_t.size() != 0 || cap_busy != 0)
      $display("FAIL cont_after_abort: got valids=%0d busy=%0d exp 0/0", cap_t.size(), cap_busy); else pass_cnt++;
  endtask

  task automatic test_abort();
    int valids = 0;
    start_burst(16'd9, 8'd10, 8'h40);
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (opOutput.Valid === 1'b1) valids++;
    end
    total_cnt++; if (valids != 3 || opOutput.Valid !== 1'b1 || opOutput.I !== 18'h38000 || opOutput.Q !== 18'h0)
      $display("FAIL abort_third: got valids=%0d v=%b i=%h q=%h exp 3/1/38000/0", valids, opOutput.Valid, opOutput.I, opOutput.Q);
    else pass_cnt++;
    ipAbort = 1'b1;
    tick();
    ipAbort = 1'b0;
    total_cnt++; if (opBusy !== 1'b0 || opOutput.Valid !== 1'b0)
      $display("FAIL abort_busy: got busy=%b v=%b exp 0/0", opBusy, opOutput.Valid); else pass_cnt++;
    capture(30);
    total_cnt++; if (cap_t.size() != 0 || cap_busy != 0)
      $display("FAIL abort_quiet: got valids=%0d busy=%0d exp 0/0", cap_t.size(), cap_busy); else pass_cnt++;
    ipRateDivider = 16'd0;
    ipBurstLength = 8'd3;
    ipStart = 1'b1;
    ipAbort = 1'b1;
    tick();
    ipStart = 1'b0;
    ipAbort = 1'b0;
    capture(12);
    total_cnt++; if (cap_t.size() != 0 || cap_busy != 0)
      $display("FAIL abort_start_same_cycle: got valids=%0d busy=%0d exp 0/0", cap_t.size(), cap_busy); else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int          et[4] = '{1, 3, 5, 7};
    logic [17:0] ei[4] = '{18'h10000, 18'h00000, 18'h30000, 18'h00000};
    logic [17:0] eq[4] = '{18'h00000, 18'h10000, 18'h00000, 18'h30000};
    int gt; logic [17:0] gi, gq;
    start_burst(16'd1, 8'd4, 8'h80);
    cap_t.delete();
    cap_i.delete();
    cap_q.delete();
    cap_busy = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 2) begin
        ipRateDivider = 16'd0;
        ipBurstLength = 8'd8;
        ipStart       = 1'b1;
      end
      if (k == 3) ipStart = 1'b0;
      if (opOutput.Valid === 1'b1) begin
        cap_t.push_back(k);
        cap_i.push_back(opOutput.I);
        cap_q.push_back(opOutput.Q);
      end
      if (opBusy === 1'b1) cap_busy++;
    end
    total_cnt++; if (cap_t.size() != 4) $display("FAIL swb_count: got %0d exp 4", cap_t.size()); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      gt = (k < cap_t.size()) ? cap_t[k] : -1;
      gi = (k < cap_i.size()) ? cap_i[k] : 'x;
      gq = (k < cap_q.size()) ? cap_q[k] : 'x;
      total_cnt++;
      if (gt != et[k] || gi !== ei[k] || gq !== eq[k])
        $display("FAIL swb_s%0d: got t=%0d i=%h q=%h exp t=%0d i=%h q=%h", k, gt, gi, gq, et[k], ei[k], eq[k]);
      else pass_cnt++;
    end
    total_cnt++; if (cap_busy != 7) $display("FAIL swb_busy_len: got %0d exp 7", cap_busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    start_burst(16'd3, 8'd0, 8'h80);
    for (int k = 1; k <= 6; k++) tick();
    total_cnt++; if (opOutput.Valid !== 1'b0 || opOutput.I !== 18'h0 || opOutput.Q !== 18'h10000 || opBusy !== 1'b1)
      $display("FAIL rst_pre_hold: got v=%b i=%h q=%h busy=%b exp 0/0/10000/1", opOutput.Valid, opOutput.I, opOutput.Q, opBusy);
    else pass_cnt++;
    #2;
    ipReset = 1'b1;
    #1;
    total_cnt++; if (opOutput.I !== 18'h0 || opOutput.Q !== 18'h0 || opOutput.Valid !== 1'b0 || opBusy !== 1'b0)
      $display("FAIL rst_async: got i=%h q=%h v=%b busy=%b exp 0/0/0/0", opOutput.I, opOutput.Q, opOutput.Valid, opBusy);
    else pass_cnt++;
    tick();
    tick();
    #2;
    ipReset = 1'b0;
    capture(15);
    total_cnt++; if (cap_t.size() != 0 || cap_busy != 0)
      $display("FAIL rst_quiet: got valids=%0d busy=%0d exp 0/0", cap_t.size(), cap_busy); else pass_cnt++;
    start_burst(16'd0, 8'd2, 8'h80);
    capture(5);
    total_cnt++;
    if (cap_t.size() != 2 || cap_t[0] != 1 || cap_i[0] !== 18'h10000 || cap_q[0] !== 18'h0 || cap_q[1] !== 18'h10000)
      $display("FAIL rst_restart_phase0: got n=%0d i0=%h q0=%h q1=%h exp 2/10000/0/10000",
               cap_t.size(), (cap_i.size() > 0) ? cap_i[0] : 18'h0, (cap_q.size() > 0) ? cap_q[0] : 18'h0,
               (cap_q.size() > 1) ? cap_q[1] : 18'h0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_divided_rate();
    test_back_to_back();
    test_continuous();
    test_abort();
    test_start_while_busy();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
